mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port cache-line memory arbiter.
// State encoding and requester port indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection for the memory arbiter.
// Round-robin by default; MEM_ARB_FIXED_PRIO_EN makes port 1 win ties.
import mem_arb_pkg::*;

module mem_arb_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_in;
  assign unused_in = last_grant ^ req[PORT_I];

  always_comb begin
    winner = PORT_I;
    if (req[PORT_D]) winner = PORT_D;
  end
`else
  always_comb begin
    winner = PORT_I;
    if (req[PORT_I] && req[PORT_D]) winner = ~last_grant;
    else if (req[PORT_D])           winner = PORT_D;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (I$/D$) cache-line arbiter onto one memory port.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority (D$ wins).
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p1_req_i,
  input  logic              p0_write_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic [DATA_W-1:0] p0_data_o,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p0_ack_o,
  output logic              p1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                win_q, win_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   p0_data_q, p0_data_d;
  logic [DATA_W-1:0]   p1_data_q, p1_data_d;
  logic                winner;

  mem_arb_pick u_pick (
    .req        ({p1_req_i, p0_req_i}),
    .last_grant (last_q),
    .winner     (winner)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    p0_data_d = p0_data_q;
    p1_data_d = p1_data_q;
    unique case (state_q)
      IDLE: begin
        if (p0_req_i || p1_req_i) begin
          win_d   = winner;
          last_d  = winner;
          wr_d    = winner ? p1_write_i : p0_write_i;
          addr_d  = winner ? p1_addr_i  : p0_addr_i;
          wdata_d = winner ? p1_data_i  : p0_data_i;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          // only reads return a line to the requester
          if (!wr_q) begin
            if (win_q == PORT_D) p1_data_d = mem_data_i;
            else                 p0_data_d = mem_data_i;
          end
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      last_q    <= PORT_D;
      win_q     <= PORT_I;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      p0_data_q <= '0;
      p1_data_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      p0_data_q <= p0_data_d;
      p1_data_q <= p1_data_d;
    end
  end

  assign mem_enable_o = (state_q == BUSY);
  assign mem_write_o  = mem_enable_o & wr_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = wdata_q;
  assign p0_ack_o     = (state_q == DONE) && (win_q == PORT_I);
  assign p1_ack_o     = (state_q == DONE) && (win_q == PORT_D);
  assign p0_data_o    = p0_data_q;
  assign p1_data_o    = p1_data_q;

endmodule
